// File: rtl/alu_pipe.sv
// alu_pipe: two-stage valid/ready ALU with Z/N/C/V flags and HOLD replay.
// Define ALU_SAT_EN for signed saturation on ADD/SUB overflow.
module alu_pipe #(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags
);

  localparam int MSB = WIDTH - 1;

`ifdef ALU_SAT_EN
  localparam logic [WIDTH-1:0] SMAX =
    {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN =
    {1'b1, {(WIDTH-1){1'b0}}};
`endif

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_SHL  = 3'd5,
    OP_SHR  = 3'd6,
    OP_HOLD = 3'd7
  } op_e;

  typedef struct packed {
    op_e              op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } s1_t;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;
  } res_t;

  logic s1_v;
  s1_t  s1_q;
  logic s2_v;
  res_t s2_q;
  res_t held_q;

  logic in_fire;
  logic s2_load;

  assign s2_load  = s1_v && (!s2_v || out_ready);
  assign in_ready = !s1_v || s2_load;
  assign in_fire  = in_valid && in_ready;

  logic [7:0]       dec;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [SHW-1:0]   sh;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   dif;
  logic [WIDTH:0]   shl_x;
  logic [WIDTH:0]   shr_x;

  assign dec   = 8'b1 << s1_q.op;
  assign a     = s1_q.a;
  assign b     = s1_q.b;
  assign sh    = s1_q.b[SHW-1:0];
  assign sum   = {1'b0, a} + {1'b0, b};
  assign dif   = {1'b0, a} - {1'b0, b};
  assign shl_x = {1'b0, a} << sh;
  assign shr_x = {a, 1'b0} >> sh;

  logic [WIDTH-1:0] r;
  logic             c;
  logic             v;
  res_t             alu_res;

  // Stage-2 datapath: result and flags of the op sitting in S1.
  always_comb begin
    r       = '0;
    c       = 1'b0;
    v       = 1'b0;
    alu_res = '0;
    unique case (1'b1)
      dec[OP_ADD]: begin
        r = sum[MSB:0];
        c = sum[WIDTH];
        v = (a[MSB] == b[MSB]) &&
            (r[MSB] != a[MSB]);
      end
      dec[OP_SUB]: begin
        r = dif[MSB:0];
        c = dif[WIDTH];
        v = (a[MSB] != b[MSB]) &&
            (r[MSB] != a[MSB]);
      end
      dec[OP_AND]: r = a & b;
      dec[OP_OR]:  r = a | b;
      dec[OP_XOR]: r = a ^ b;
      dec[OP_SHL]: begin
        r = shl_x[MSB:0];
        c = shl_x[WIDTH];
      end
      dec[OP_SHR]: begin
        r = shr_x[WIDTH:1];
        c = shr_x[0];
      end
      dec[OP_HOLD]: r = '0;
      default: r = '0;
    endcase
`ifdef ALU_SAT_EN
    if (v) begin
      r = a[MSB] ? SMIN : SMAX;
    end
`endif
    alu_res.result = r;
    alu_res.flags  = {v, c, r[MSB], r == '0};
    if (dec[OP_HOLD]) begin
      alu_res = held_q;
    end
  end

  // S1: capture accepted op, drain when S2 takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v <= 1'b0;
      s1_q <= '0;
    end else if (in_fire) begin
      s1_v    <= 1'b1;
      s1_q.op <= op_e'(in_op);
      s1_q.a  <= in_a;
      s1_q.b  <= in_b;
    end else if (s2_load) begin
      s1_v <= 1'b0;
    end
  end

  // S2: output register, held stable while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v <= 1'b0;
      s2_q <= '0;
    end else if (s2_load) begin
      s2_v <= 1'b1;
      s2_q <= alu_res;
    end else if (out_ready) begin
      s2_v <= 1'b0;
    end
  end

  // Held copy of the last non-HOLD result, in program order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held_q <= '0;
    end else if (s2_load && !dec[OP_HOLD]) begin
      held_q <= alu_res;
    end
  end

  assign out_valid  = s2_v;
  assign out_result = s2_q.result;
  assign out_flags  = s2_q.flags;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed checks of alu_pipe at WIDTH=8.
// Expected values are hand computed; ALU_SAT_EN selects saturating ones.
module tb_alu_pipe;

  localparam int W = 8;

  localparam logic [2:0] OADD = 3'd0;
  localparam logic [2:0] OSUB = 3'd1;
  localparam logic [2:0] OAND = 3'd2;
  localparam logic [2:0] OOR  = 3'd3;
  localparam logic [2:0] OXOR = 3'd4;
  localparam logic [2:0] OSHL = 3'd5;
  localparam logic [2:0] OSHR = 3'd6;
  localparam logic [2:0] OHLD = 3'd7;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_op;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic [3:0]   out_flags;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  logic [2:0]   s_op [8];
  logic [W-1:0] s_a  [8];
  logic [W-1:0] s_b  [8];
  logic [W-1:0] s_r  [8];
  logic [3:0]   s_f  [8];

  alu_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_flags (out_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got 0x%0h, want 0x%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input string tag,
                       input logic [2:0] op,
                       input logic [W-1:0] a,
                       input logic [W-1:0] b,
                       input logic [W-1:0] er,
                       input logic [3:0] ef);
    chk({tag, "/rdy"}, in_ready, 1);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    step();
    in_valid = 1'b0;
    chk({tag, "/lat"}, out_valid, 0);
    step();
    chk({tag, "/vld"}, out_valid, 1);
    chk({tag, "/res"}, out_result, er);
    chk({tag, "/flg"}, out_flags, ef);
  endtask

  initial begin
    int iidx;
    int oidx;
    int cyc;
    logic stalled;
    logic blocked;

    s_op[0] = OADD; s_a[0] = 8'h10; s_b[0] = 8'h20;
    s_r[0] = 8'h30; s_f[0] = 4'b0000;
    s_op[1] = OHLD; s_a[1] = 8'h00; s_b[1] = 8'h00;
    s_r[1] = 8'h30; s_f[1] = 4'b0000;
    s_op[2] = OAND; s_a[2] = 8'hF0; s_b[2] = 8'h3C;
    s_r[2] = 8'h30; s_f[2] = 4'b0000;
    s_op[3] = OOR;  s_a[3] = 8'h0F; s_b[3] = 8'h80;
    s_r[3] = 8'h8F; s_f[3] = 4'b0010;
    s_op[4] = OSUB; s_a[4] = 8'h80; s_b[4] = 8'h01;
`ifdef ALU_SAT_EN
    s_r[4] = 8'h80; s_f[4] = 4'b1010;
`else
    s_r[4] = 8'h7F; s_f[4] = 4'b1000;
`endif
    s_op[5] = OXOR; s_a[5] = 8'hAA; s_b[5] = 8'hAA;
    s_r[5] = 8'h00; s_f[5] = 4'b0001;
    s_op[6] = OHLD; s_a[6] = 8'h55; s_b[6] = 8'h55;
    s_r[6] = 8'h00; s_f[6] = 4'b0001;
    s_op[7] = OSHL; s_a[7] = 8'h03; s_b[7] = 8'h0A;
    s_r[7] = 8'h0C; s_f[7] = 4'b0000;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_op     = 3'd0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    step();
    step();
    chk("rst/vld", out_valid, 0);
    chk("rst/res", out_result, 0);
    chk("rst/flg", out_flags, 0);
    rst = 1'b0;
    step();
    chk("rst/rdy", in_ready, 1);

    do_op("hold0", OHLD, 8'h12, 8'h34, 8'h00, 4'b0000);
`ifdef ALU_SAT_EN
    do_op("add7f", OADD, 8'h7F, 8'h01, 8'h7F, 4'b1000);
    do_op("addneg", OADD, 8'h80, 8'hFF, 8'h80, 4'b1110);
`else
    do_op("add7f", OADD, 8'h7F, 8'h01, 8'h80, 4'b1010);
    do_op("addneg", OADD, 8'h80, 8'hFF, 8'h7F, 4'b1100);
`endif
    do_op("sub57", OSUB, 8'h05, 8'h07, 8'hFE, 4'b0110);
    do_op("sub33", OSUB, 8'h33, 8'h33, 8'h00, 4'b0001);
    do_op("shl81", OSHL, 8'h81, 8'h01, 8'h02, 4'b0100);
    do_op("shr0", OSHR, 8'h01, 8'h00, 8'h01, 4'b0000);
    do_op("shr7", OSHR, 8'h80, 8'h0F, 8'h01, 4'b0000);
    step();

    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin
        chk("bb/rdy", in_ready, 1);
        in_valid = 1'b1;
        in_op    = s_op[i];
        in_a     = s_a[i];
        in_b     = s_b[i];
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (i >= 1) begin
        chk("bb/vld", out_valid, 1);
        chk("bb/res", out_result, s_r[i-1]);
        chk("bb/flg", out_flags, s_f[i-1]);
      end
    end
    step();
    chk("bb/drain", out_valid, 0);

    iidx    = 0;
    oidx    = 0;
    cyc     = 0;
    stalled = 1'b0;
    blocked = 1'b0;
    while (oidx < 8 && cyc < 60) begin
      out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      in_valid  = iidx < 8;
      if (iidx < 8) begin
        in_op = s_op[iidx];
        in_a  = s_a[iidx];
        in_b  = s_b[iidx];
      end
      #1;
      if (stalled) begin
        chk("st/hold", out_valid, 1);
      end
      if (out_valid) begin
        chk("st/res", out_result, s_r[oidx]);
        chk("st/flg", out_flags, s_f[oidx]);
        if (out_ready) begin
          oidx++;
        end
      end
      if (in_valid && !in_ready) begin
        blocked = 1'b1;
      end
      stalled = out_valid && !out_ready;
      if (in_valid && in_ready) begin
        iidx++;
      end
      step();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("st/count", oidx, 8);
    chk("st/block", blocked, 1);
    step();
    step();
    chk("st/drain", out_valid, 0);

    do_op("xor", OXOR, 8'hF0, 8'hFF, 8'h0F, 4'b0000);
    do_op("hold1", OHLD, 8'h00, 8'h00, 8'h0F, 4'b0000);
    do_op("hold2", OHLD, 8'hFF, 8'hFF, 8'h0F, 4'b0000);
    step();

    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_op     = OADD;
    in_a      = 8'h01;
    in_b      = 8'h01;
    step();
    in_a = 8'h02;
    in_b = 8'h02;
    step();
    in_valid = 1'b0;
    chk("fl/pre", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("fl/vld", out_valid, 0);
    chk("fl/res", out_result, 0);
    chk("fl/flg", out_flags, 0);
    step();
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("fl/none", out_valid, 0);
    end
    do_op("hold3", OHLD, 8'h00, 8'h00, 8'h00, 4'b0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle 8-bit datapath ALU.
- Accepts one operation per cycle through a valid/ready handshake and returns a registered result plus Z/N/C/V flags two cycles later.
- Sits between the register-interface command decoder and the result/status registers of the AXI4-Lite slave.
- Adds SUB/OR/shift ops, flags, backpressure, and a well-defined HOLD (memory-op) result in place of a combinational latch.

Parameters:
- WIDTH, 8, operand/result width in bits; power of 2, 4..64.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation presented.
- in_ready  out  1  block can accept an operation this cycle.
- in_op  in  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 HOLD.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B; shifts use in_b[SHW-1:0] only.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- out_result  out  WIDTH  result.
- out_flags  out  4  {V,C,N,Z}.

Behaviour:
- Reset: all pipeline valids, out_valid, out_result, out_flags, and the held result/flags are 0. in_ready is 1 one cycle after reset deassertion. Reset asserted mid-operation discards all in-flight operations immediately, with no partial output.
- Transfers:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - out_* are held stable while out_valid && !out_ready.
- Pipeline:
  - S1 registers op/a/b.
  - S2 computes and registers result/flags; S2 drives out_*.
  - S2 loads when S1 valid && (!S2 valid || out_ready).
  - in_ready = !S1 valid || S2 loads. This is combinational from out_ready; no in_valid -> in_ready path.
- Latency and throughput:
  - Latency is 2 cycles, accept edge to out_valid.
  - Throughput is 1 op per cycle with out_ready held high.
  - Ordering is strictly in order; no drops or duplicates under any out_ready pattern.
- Arithmetic (all modulo 2^WIDTH):
  - ADD: C = carry out; V = signed overflow.
  - SUB: A-B; C = borrow (A<B unsigned); V = signed overflow.
  - AND/OR/XOR: C = 0, V = 0.
  - SHL/SHR are logical. C = last bit shifted out; a shift amount of 0 gives C = 0. V = 0.
  - Z = (result == 0); N = result[WIDTH-1], for all non-HOLD ops.
- HOLD:
  - Returns the result and flags of the most recent non-HOLD op to leave S2 compute, in program order. After reset this is 0 with flags 0.
  - Still occupies a pipeline slot and produces an output transfer.
- Held register: updated on every S2 load of a non-HOLD op. Back-to-back ADD then HOLD returns the ADD result.

Optional Feature:
- ALU_SAT_EN defined: ADD/SUB saturate as signed values to the max/min representable value when V would be set. V still reports the saturation event; C is unchanged.
- ALU_SAT_EN undefined: wrap-around as described above.
- Both builds have identical ports.

Test Plan:
- Reset then ADD a=0x7F b=0x01, out_ready=1 -> 2 cycles later result=0x80 flags V=1 N=1 C=0 Z=0 (with ALU_SAT_EN: result=0x7F, V=1).
- SUB a=0x05 b=0x07 -> result=0xFE C=1 N=1 V=0; SUB 0x33,0x33 -> 0x00 Z=1 C=0.
- SHL a=0x81 b=1 -> 0x02 C=1; SHR a=0x01 b=0 -> 0x01 C=0; SHR a=0x80 b=0x0F (uses b[2:0]=7) -> 0x01 C=0.
- Stream of 8 ops back-to-back with out_ready=1 -> 8 results on consecutive cycles, in order.
- Same stream with out_ready toggling 1,0,0,1,... -> in_ready drops when both stages are full; out_* are stable while stalled; all 8 results are delivered in order.
- HOLD right after reset -> 0, flags 0; XOR 0xF0,0xFF then HOLD -> 0x0F twice. Assert rst while 2 ops are in flight -> out_valid=0 immediately, and neither op appears afterwards.
